window_cache: RTL and testbench

//  Parametrised successor to the fixed 3x3 RGB line cache. Builds a (2R+1)x(2R+1) pixel neighbourhood for any

---
 rtl/window_cache_if.sv | 30 +++
 rtl/window_cache.sv | 199 +++++++++++++++++++
 tb/tb_window_cache.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_cache_if.sv
// Handshake and data bundle between the line buffer, window_cache and the window consumer.
interface window_cache_if #(
  parameter int unsigned CH     = 3,
  parameter int unsigned W      = 8,
  parameter int unsigned RADIUS = 1,
  parameter int unsigned AW     = 8
);
  localparam int unsigned K = 2 * RADIUS + 1;

  logic                  lineChange;
  logic                  advance;
  logic [K*CH*W-1:0]     colIn;
  logic [AW-1:0]         readAddr;
  logic                  ready;
  logic [AW-1:0]         curPxl;
  logic [K*K*CH*W-1:0]   window;
  logic                  advErr;

  // Driver / consumer side
  modport master (
    output lineChange, advance, colIn,
    input  readAddr, ready, curPxl, window, advErr
  );

  // window_cache side
  modport slave (
    input  lineChange, advance, colIn,
    output readAddr, ready, curPxl, window, advErr
  );
endinterface

// File: rtl/window_cache.sv
// Sliding (2R+1)x(2R+1) pixel neighbourhood built from line-buffer columns.
// Column reads are tracked by a READLAT-deep tag pipeline so data can be captured
// exactly when it arrives; lineChange flushes the pipeline so stale data never lands.
module window_cache #(
  parameter int unsigned CH        = 3,
  parameter int unsigned W         = 8,
  parameter int unsigned RADIUS    = 1,
  parameter int unsigned LINEWIDTH = 240,
  parameter int unsigned READLAT   = 1,
  parameter int unsigned EDGEMODE  = 0,
  parameter int unsigned AW        = 8
) (
  input  logic           clk,
  input  logic           rst,
  window_cache_if.slave  bus
);

  localparam int unsigned K  = 2 * RADIUS + 1;
  localparam int unsigned CW = K * CH * W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPrime = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StFetch = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     col_q [K];
  logic [CW-1:0]     col_d [K];
  logic [AW-1:0]     read_addr_q, read_addr_d;
  logic [AW-1:0]     cur_pxl_q, cur_pxl_d;
  logic              ready_q, ready_d;
  logic              adv_err_q, adv_err_d;
  // Next prime column address to request (0..RADIUS, RADIUS+1 = done issuing)
  logic [2:0]        issue_q, issue_d;

  // Tag pipeline: stage i describes the read issued i+1 cycles ago.
  // v = valid, p = prime column (else shift column), e = edge fill, a = prime column index
  logic [READLAT:0]      tag_v_q, tag_v_d;
  logic [READLAT:0]      tag_p_q, tag_p_d;
  logic [READLAT:0]      tag_e_q, tag_e_d;
  logic [READLAT:0][1:0] tag_a_q, tag_a_d;

  logic              land_v, land_p, land_e;
  logic [1:0]        land_a;
  logic [AW:0]       next_addr;
  logic              next_in_line;
  logic              adv_ok;
  logic              prime_edge;
  logic [K*K*CH*W-1:0] window_flat;

  assign land_v = tag_v_q[READLAT];
  assign land_p = tag_p_q[READLAT];
  assign land_e = tag_e_q[READLAT];
  assign land_a = tag_a_q[READLAT];

  // One extra bit so curPxl+R+1 cannot wrap before the line-end compare
  assign next_addr    = {1'b0, cur_pxl_q} + (AW+1)'(RADIUS + 1);
  assign next_in_line = next_addr <= (AW+1)'(LINEWIDTH - 1);
  assign adv_ok       = bus.advance && ready_q && (state_q == StRun) &&
                        (cur_pxl_q != AW'(LINEWIDTH - 1));
  assign prime_edge   = (32'(issue_q) + RADIUS) > (LINEWIDTH - 1);

  // Next-state: lineChange restart, prime/advance read issue, column landing
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    read_addr_d = read_addr_q;
    cur_pxl_d   = cur_pxl_q;
    ready_d     = ready_q;
    adv_err_d   = 1'b0;
    issue_d     = issue_q;
    tag_v_d     = {tag_v_q[READLAT-1:0], 1'b0};
    tag_p_d     = {tag_p_q[READLAT-1:0], 1'b0};
    tag_e_d     = {tag_e_q[READLAT-1:0], 1'b0};
    tag_a_d     = {tag_a_q[READLAT-1:0], 2'b00};

    if (bus.lineChange) begin
      // Flush in-flight reads and request column 0 right away
      state_d     = StPrime;
      cur_pxl_d   = '0;
      ready_d     = 1'b0;
      read_addr_d = '0;
      issue_d     = 3'd1;
      tag_v_d     = '0;
      tag_p_d     = '0;
      tag_e_d     = '0;
      tag_a_d     = '0;
      tag_v_d[0]  = 1'b1;
      tag_p_d[0]  = 1'b1;
    end else begin
      adv_err_d = bus.advance && !adv_ok;

      if ((state_q == StPrime) && (issue_q <= 3'(RADIUS))) begin
        tag_v_d[0] = 1'b1;
        tag_p_d[0] = 1'b1;
        tag_a_d[0] = issue_q[1:0];
        if (prime_edge) begin
          tag_e_d[0] = 1'b1;
        end else begin
          read_addr_d = AW'(issue_q);
        end
        issue_d = issue_q + 3'd1;
      end

      if (adv_ok) begin
        state_d    = StFetch;
        ready_d    = 1'b0;
        tag_v_d[0] = 1'b1;
        tag_p_d[0] = 1'b0;
        tag_e_d[0] = !next_in_line;
        if (next_in_line) begin
          read_addr_d = next_addr[AW-1:0];
        end
      end

      if (land_v) begin
        if (land_p) begin
          if (land_a == 2'd0) begin
            // Column 0 seeds the centre and the left border
            for (int unsigned k = 0; k < RADIUS; k++) begin
              col_d[k] = (EDGEMODE != 0) ? '0 : bus.colIn;
            end
            col_d[RADIUS] = bus.colIn;
          end else begin
            for (int unsigned k = 1; k < K; k++) begin
              if (k == RADIUS + 32'(land_a)) begin
                col_d[k] = land_e ? ((EDGEMODE != 0) ? '0 : col_q[k-1]) : bus.colIn;
              end
            end
          end
          if (32'(land_a) == RADIUS) begin
            ready_d = 1'b1;
            state_d = StRun;
          end
        end else begin
          for (int unsigned k = 0; k + 1 < K; k++) begin
            col_d[k] = col_q[k+1];
          end
          col_d[K-1] = land_e ? ((EDGEMODE != 0) ? '0 : col_q[K-1]) : bus.colIn;
          cur_pxl_d  = cur_pxl_q + AW'(1);
          ready_d    = 1'b1;
          state_d    = StRun;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      read_addr_q <= '0;
      cur_pxl_q   <= '0;
      ready_q     <= 1'b0;
      adv_err_q   <= 1'b0;
      issue_q     <= '0;
      tag_v_q     <= '0;
      tag_p_q     <= '0;
      tag_e_q     <= '0;
      tag_a_q     <= '0;
      for (int unsigned k = 0; k < K; k++) begin
        col_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      read_addr_q <= read_addr_d;
      cur_pxl_q   <= cur_pxl_d;
      ready_q     <= ready_d;
      adv_err_q   <= adv_err_d;
      issue_q     <= issue_d;
      tag_v_q     <= tag_v_d;
      tag_p_q     <= tag_p_d;
      tag_e_q     <= tag_e_d;
      tag_a_q     <= tag_a_d;
      for (int unsigned k = 0; k < K; k++) begin
        col_q[k] <= col_d[k];
      end
    end
  end

  // Re-pack column storage into the row-major window layout
  always_comb begin
    window_flat = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned k = 0; k < K; k++) begin
        for (int unsigned c = 0; c < CH; c++) begin
          window_flat[((r*K+k)*CH+c)*W +: W] = col_q[k][(r*CH+c)*W +: W];
        end
      end
    end
  end

  assign bus.window   = window_flat;
  assign bus.readAddr = read_addr_q;
  assign bus.curPxl   = cur_pxl_q;
  assign bus.ready    = ready_q;
  assign bus.advErr   = adv_err_q;

endmodule

// File: tb/tb_window_cache.sv
// Bench for window_cache: two instances (R=1/RL=1/replicate and R=2/RL=3/zero-fill),
// an emulated line buffer with read latency, a vector table and a pixel-level model.
module tb_window_cache;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int LW = 240;
  localparam int AW = 8;
  localparam int WB = 25 * CH * W;
  localparam int CB = 5 * CH * W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          sel    = 1'b0;
  logic          lc     = 1'b0;
  logic          adv    = 1'b0;
  logic          inject = 1'b0;
  logic [CB-1:0] col_drv = '0;

  window_cache_if #(.CH(CH), .W(W), .RADIUS(1), .AW(AW)) if_a ();
  window_cache_if #(.CH(CH), .W(W), .RADIUS(2), .AW(AW)) if_b ();

  window_cache #(.CH(CH), .W(W), .RADIUS(1), .LINEWIDTH(LW), .READLAT(1), .EDGEMODE(0),
                 .AW(AW)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  window_cache #(.CH(CH), .W(W), .RADIUS(2), .LINEWIDTH(LW), .READLAT(3), .EDGEMODE(1),
                 .AW(AW)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  assign if_a.lineChange = lc & ~sel;
  assign if_a.advance    = adv & ~sel;
  assign if_a.colIn      = col_drv[3*CH*W-1:0];
  assign if_b.lineChange = lc & sel;
  assign if_b.advance    = adv & sel;
  assign if_b.colIn      = col_drv;

  logic [AW-1:0] ra_o, cur_o;
  logic          rdy_o, err_o;
  logic [WB-1:0] win_o;
  assign ra_o  = sel ? if_b.readAddr : if_a.readAddr;
  assign cur_o = sel ? if_b.curPxl : if_a.curPxl;
  assign rdy_o = sel ? if_b.ready : if_a.ready;
  assign err_o = sel ? if_b.advErr : if_a.advErr;
  assign win_o = sel ? if_b.window : {{(WB-9*CH*W){1'b0}}, if_a.window};

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] pix [LW][5][CH];
  int hist[$];

  // Reference model state (transaction level)
  int m_cur, m_rem, m_ra, m_pn;
  bit m_ready, m_err, m_inc;

  typedef struct {
    bit l; bit a; bit rdy; bit err; int ra; int cur;
  } vec_t;
  vec_t tbl [12];

  function automatic int rr();  return sel ? 2 : 1; endfunction
  function automatic int rl();  return sel ? 3 : 1; endfunction
  function automatic bit em();  return sel; endfunction

  task automatic chk(input string nm, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic fill(input bit rnd);
    for (int x = 0; x < LW; x++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < CH; c++)
          pix[x][r][c] = rnd ? 8'($urandom_range(0, 127)) : 8'(x);
  endtask

  function automatic logic [CB-1:0] col_of(input int x);
    logic [CB-1:0] v = '0;
    for (int r = 0; r < 2 * rr() + 1; r++)
      for (int c = 0; c < CH; c++) v[(r*CH+c)*W +: W] = pix[x][r][c];
    return v;
  endfunction

  // Window centred on pixel p, built straight from the line contents and border rule
  function automatic logic [WB-1:0] exp_win(input int p);
    logic [WB-1:0] v = '0;
    int kk = 2 * rr() + 1;
    int x;
    logic [7:0] b;
    for (int r = 0; r < kk; r++)
      for (int k = 0; k < kk; k++)
        for (int c = 0; c < CH; c++) begin
          x = p - rr() + k;
          if (x < 0) b = em() ? 8'h00 : pix[0][r][c];
          else if (x > LW - 1) b = em() ? 8'h00 : pix[LW-1][r][c];
          else b = pix[x][r][c];
          v[((r*kk+k)*CH+c)*W +: W] = b;
        end
    return v;
  endfunction

  function automatic bit has_aa(input logic [WB-1:0] v);
    logic [7:0] b;
    for (int i = 0; i < WB / 8; i++) begin
      b = v[i*8 +: 8];
      if (b == 8'hAA) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_rem = 0; m_ra = 0; m_pn = 4;
    m_ready = 0; m_err = 0; m_inc = 0;
  endtask

  // Expected outputs one cycle after inputs (l, a)
  task automatic model_step(input bit l, input bit a);
    bit acc;
    if (l) begin
      m_cur = 0; m_ready = 0; m_rem = 1 + rr() + rl(); m_inc = 0;
      m_err = 0; m_ra = 0; m_pn = 1;
    end else begin
      acc   = a && m_ready && (m_cur < LW - 1);
      m_err = a && !acc;
      if (m_pn <= rr()) begin
        if (rr() + m_pn <= LW - 1) m_ra = m_pn;
        m_pn++;
      end
      if (acc) begin
        m_ready = 0; m_rem = rl() + 1; m_inc = 1;
        if (m_cur + rr() + 1 <= LW - 1) m_ra = m_cur + rr() + 1;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_ready = 1;
          if (m_inc) m_cur++;
          m_inc = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs (line buffer returns data READLAT cycles after readAddr)
  task automatic tick(input bit l, input bit a);
    int src;
    lc  = l;
    adv = a;
    if (inject) col_drv = {(CB/8){8'hAA}};
    else begin
      src     = (hist.size() > rl()) ? hist[hist.size() - 1 - rl()] : 0;
      col_drv = col_of(src);
    end
    model_step(l, a);
    @(posedge clk);
    @(negedge clk);
    lc  = 1'b0;
    adv = 1'b0;
    hist.push_back(int'(ra_o));
    if (hist.size() > 16) void'(hist.pop_front());
  endtask

  task automatic check_cycle(input string tag);
    chk({tag, " ready"}, WB'(rdy_o), WB'(m_ready));
    chk({tag, " curPxl"}, WB'(cur_o), WB'(m_cur));
    chk({tag, " advErr"}, WB'(err_o), WB'(m_err));
    chk({tag, " readAddr"}, WB'(ra_o), WB'(m_ra));
    if (m_ready) chk({tag, " window"}, win_o, exp_win(m_cur));
  endtask

  task automatic reset_dut();
    rst = 1'b0; lc = 1'b0; adv = 1'b0; inject = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    hist.delete();
    hist.push_back(int'(ra_o));
    model_reset();
  endtask

  task automatic run_until_ready(input string tag);
    for (int g = 0; g < 32 && !m_ready; g++) begin
      tick(1'b0, 1'b0);
      check_cycle(tag);
    end
  endtask

  task automatic adv_to(input int target, input string tag);
    for (int g = 0; g < 5000 && m_cur < target; g++) begin
      tick(1'b0, m_ready);
      check_cycle(tag);
    end
  endtask

  task automatic rand_run(input int n, input string tag);
    bit l, a;
    tick(1'b1, 1'b0);
    check_cycle(tag);
    for (int i = 0; i < n; i++) begin
      l = ($urandom_range(0, 1499) == 0);
      a = ($urandom_range(0, 3) != 0);
      tick(l, a);
      check_cycle(tag);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           l  a  rdy err ra cur
    tbl[0]  = '{0, 1, 0, 1, 0, 0};  // advance in IDLE
    tbl[1]  = '{0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0};  // lineChange: cycle 1 readAddr 0
    tbl[3]  = '{0, 0, 0, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 1, 0};
    tbl[5]  = '{0, 0, 1, 0, 1, 0};  // ready at cycle 4
    tbl[6]  = '{0, 1, 0, 0, 2, 0};  // accepted advance
    tbl[7]  = '{0, 1, 0, 1, 2, 0};  // advance while busy
    tbl[8]  = '{0, 0, 1, 0, 2, 1};
    tbl[9]  = '{0, 0, 1, 0, 2, 1};
    tbl[10] = '{1, 1, 0, 0, 0, 0};  // lineChange wins, no advErr
    tbl[11] = '{0, 1, 0, 1, 1, 0};  // advance during prime

    // Reset values
    sel = 1'b0;
    fill(1'b0);
    #1;
    chk("rst ready", WB'(rdy_o), '0);
    chk("rst readAddr", WB'(ra_o), '0);
    chk("rst curPxl", WB'(cur_o), '0);
    chk("rst advErr", WB'(err_o), '0);
    chk("rst window", win_o, '0);

    // Vector table on the R=1 instance, column index data
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].l, tbl[i].a);
      chk($sformatf("vec%0d ready", i), WB'(rdy_o), WB'(tbl[i].rdy));
      chk($sformatf("vec%0d advErr", i), WB'(err_o), WB'(tbl[i].err));
      chk($sformatf("vec%0d readAddr", i), WB'(ra_o), WB'(tbl[i].ra));
      chk($sformatf("vec%0d curPxl", i), WB'(cur_o), WB'(tbl[i].cur));
      if (tbl[i].rdy) chk($sformatf("vec%0d window", i), win_o, exp_win(tbl[i].cur));
    end

    // Whole line with back-to-back advances, then past the end
    reset_dut();
    tick(1'b1, 1'b0);
    check_cycle("line");
    run_until_ready("line");
    adv_to(LW - 1, "line");
    tick(1'b0, 1'b1);
    check_cycle("eol");
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      check_cycle("eol hold");
    end

    // lineChange during FETCH with poisoned in-flight data
    reset_dut();
    fill(1'b1);
    tick(1'b1, 1'b0);
    check_cycle("flush");
    run_until_ready("flush");
    tick(1'b0, 1'b1);
    check_cycle("flush");
    inject = 1'b1;
    tick(1'b1, 1'b0);
    check_cycle("flush lc");
    tick(1'b0, 1'b0);
    inject = 1'b0;
    check_cycle("flush lc");
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, m_ready);
      check_cycle("flush after");
      chk("flush noAA", WB'(has_aa(win_o)), '0);
    end

    // Random traffic on the R=1 instance
    reset_dut();
    rand_run(4000, "rndA");

    // R=2, READLAT=3, zero-fill instance
    sel = 1'b1;
    reset_dut();
    fill(1'b1);
    tick(1'b1, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("primeB c%0d ready", c), WB'(rdy_o), WB'(c == 7));
      chk($sformatf("primeB c%0d readAddr", c), WB'(ra_o), WB'((c - 1 > 2) ? 2 : c - 1));
      if (c < 7) tick(1'b0, 1'b0);
    end
    chk("primeB window", win_o, exp_win(0));
    adv_to(LW - 2, "lineB");
    chk("lineB cur238", WB'(cur_o), WB'(LW - 2));
    chk("lineB window238", win_o, exp_win(LW - 2));
    adv_to(LW - 1, "lineB");
    tick(1'b0, 1'b1);
    check_cycle("eolB");
    reset_dut();
    rand_run(4000, "rndB");

    // Asynchronous reset in the middle of a fetch
    sel = 1'b0;
    reset_dut();
    fill(1'b1);
    tick(1'b1, 1'b0);
    run_until_ready("arst");
    tick(1'b0, 1'b1);
    check_cycle("arst fetch");
    #2 rst = 1'b0;
    #1;
    chk("arst ready", WB'(rdy_o), '0);
    chk("arst readAddr", WB'(ra_o), '0);
    chk("arst curPxl", WB'(cur_o), '0);
    chk("arst advErr", WB'(err_o), '0);
    chk("arst window", win_o, '0);
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    hist.delete();
    hist.push_back(int'(ra_o));
    model_reset();
    tick(1'b0, 1'b1);
    check_cycle("arst idle adv");
    tick(1'b1, 1'b0);
    check_cycle("arst prime");
    run_until_ready("arst prime");
    adv_to(5, "arst run");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
